// File: rtl/fpmult_pkg.sv
// Shared FPMult types and constants: packed IEEE-754 single layout and the
// payload carried between the rounding and packing stages.
package fpmult_pkg;

    localparam int F_EXP_W = 8;
    localparam int F_MAN_W = 23;

    localparam int              EXP_BIAS = 127;
    localparam logic [7:0]      EXP_MAX  = 8'hFF;
    localparam logic [31:0]     QNAN     = 32'h7FC00000;

    typedef struct packed {
        logic               sign;
        logic [F_EXP_W-1:0] exp;
        logic [F_MAN_W-1:0] man;
    } float_t;

    // Exponent keeps one extra bit so under/overflow survive until packing.
    typedef struct packed {
        logic               sign;
        logic [F_EXP_W:0]   e;
        logic [F_MAN_W-1:0] m;
        logic               inexact;
        logic               nan;
        logic               inf;
        logic               zero;
    } s1_t;

endpackage

// File: rtl/fpmult_round_pack_if.sv
// Handshake and data bundle between the normalize stage, the round/pack block
// and its consumer.
interface fpmult_round_pack_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   Sign;
    logic [EXP_W:0]         RoundE;
    logic [EXP_W:0]         RoundEP;
    logic [MAN_W:0]         RoundM;
    logic [MAN_W:0]         RoundMP;
    logic                   G;
    logic                   R;
    logic                   S;
    logic                   SpecNaN;
    logic                   SpecInf;
    logic                   SpecZero;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   Z;
    logic                   flags_clr;
    logic                   flag_ovf;
    logic                   flag_unf;
    logic                   flag_inx;

    modport master (
        output in_valid, Sign, RoundE, RoundEP, RoundM, RoundMP, G, R, S,
               SpecNaN, SpecInf, SpecZero, out_ready, flags_clr,
        input  in_ready, out_valid, Z, flag_ovf, flag_unf, flag_inx
    );

    modport slave (
        input  in_valid, Sign, RoundE, RoundEP, RoundM, RoundMP, G, R, S,
               SpecNaN, SpecInf, SpecZero, out_ready, flags_clr,
        output in_ready, out_valid, Z, flag_ovf, flag_unf, flag_inx
    );
endinterface

// File: rtl/fpmult_round_select.sv
// Round-to-nearest-even candidate select; purely combinational so FPAdd can
// reuse it in front of its own registers.
module fpmult_round_select #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W:0]   round_e_i,
    input  logic [EXP_W:0]   round_ep_i,
    input  logic [MAN_W:0]   round_m_i,
    input  logic [MAN_W:0]   round_mp_i,
    input  logic             g_i,
    input  logic             r_i,
    input  logic             s_i,
    output logic [EXP_W:0]   e_o,
    output logic [MAN_W-1:0] m_o,
    output logic             inexact_o
);
    logic up;
    logic unused_m_msb;

    // Truncated candidate never carries; its top bit is structurally zero.
    assign unused_m_msb = round_m_i[MAN_W];

    assign up        = g_i & (r_i | s_i | round_m_i[0]);
    assign inexact_o = g_i | r_i | s_i;

    always_comb begin
        e_o = round_e_i;
        m_o = round_m_i[MAN_W-1:0];
        if (up) begin
            if (round_mp_i[MAN_W]) begin
                e_o = round_ep_i;
                m_o = '0;
            end else begin
                m_o = round_mp_i[MAN_W-1:0];
            end
        end
    end
endmodule

// File: rtl/fpmult_round_pack.sv
// Final FPMult stage: registered RNE select, then classify/pack into an
// IEEE-754 single with sticky overflow/underflow/inexact flags.
module fpmult_round_pack
    import fpmult_pkg::*;
#(
    parameter int EXP_W = F_EXP_W,
    parameter int MAN_W = F_MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fpmult_round_pack_if.slave   bus
);
    s1_t        s1_d, s1_q;
    float_t     z_d, z_q;
    logic       s1_v_q, s2_v_q;
    logic       ovf_q, unf_q, inx_q;
    logic       set_ovf, set_unf, set_inx;
    logic       s1_adv, s2_adv, in_fire, s2_load;
    logic [EXP_W:0]   sel_e;
    logic [MAN_W-1:0] sel_m;
    logic             sel_inx;

    assign s2_adv  = ~s2_v_q | bus.out_ready;
    assign s1_adv  = ~s1_v_q | s2_adv;
    assign in_fire = bus.in_valid & s1_adv;
    assign s2_load = s1_v_q & s2_adv;

    fpmult_round_select #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_sel (
        .round_e_i  (bus.RoundE),
        .round_ep_i (bus.RoundEP),
        .round_m_i  (bus.RoundM),
        .round_mp_i (bus.RoundMP),
        .g_i        (bus.G),
        .r_i        (bus.R),
        .s_i        (bus.S),
        .e_o        (sel_e),
        .m_o        (sel_m),
        .inexact_o  (sel_inx)
    );

    always_comb begin
        s1_d.sign    = bus.Sign;
        s1_d.e       = sel_e;
        s1_d.m       = sel_m;
        s1_d.inexact = sel_inx;
        s1_d.nan     = bus.SpecNaN;
        s1_d.inf     = bus.SpecInf;
        s1_d.zero    = bus.SpecZero;
    end

    // Classification is done on the stage-1 register so Z and the flags
    // update together on the edge that makes the result visible.
    always_comb begin
        z_d     = '{sign: s1_q.sign, exp: s1_q.e[EXP_W-1:0], man: s1_q.m};
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_inx = s1_q.inexact;
        if (s1_q.nan) begin
            z_d     = QNAN;
            set_inx = 1'b0;
        end else if (s1_q.inf) begin
            z_d     = '{sign: s1_q.sign, exp: EXP_MAX, man: '0};
            set_inx = 1'b0;
        end else if (s1_q.zero) begin
            z_d     = '{sign: s1_q.sign, exp: '0, man: '0};
            set_inx = 1'b0;
        end else if (int'($signed(s1_q.e)) <= 0) begin
            z_d     = '{sign: s1_q.sign, exp: '0, man: '0};
            set_unf = 1'b1;
            set_inx = 1'b1;
        end else if (int'($signed(s1_q.e)) >= 2*EXP_BIAS+1) begin
            z_d     = '{sign: s1_q.sign, exp: EXP_MAX, man: '0};
            set_ovf = 1'b1;
            set_inx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            z_q    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inx_q  <= 1'b0;
        end else begin
            if (s1_adv)  s1_v_q <= bus.in_valid;
            if (in_fire) s1_q   <= s1_d;
            if (s2_adv)  s2_v_q <= s1_v_q;
            if (s2_load) z_q    <= z_d;
            // Clear wins over a same-cycle set; s2_load fires once per result.
            if (bus.flags_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
                inx_q <= 1'b0;
            end else if (s2_load) begin
                ovf_q <= ovf_q | set_ovf;
                unf_q <= unf_q | set_unf;
                inx_q <= inx_q | set_inx;
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.Z         = z_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_unf  = unf_q;
    assign bus.flag_inx  = inx_q;
endmodule

// File: tb/tb_fpmult_round_pack.sv
// Directed bench for fpmult_round_pack: rounding cases, range limits,
// specials, sticky-flag timing, backpressure and reset while full.
module tb_fpmult_round_pack;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   k_in, k_out, cyc;
    logic rdy, seen;
    logic [31:0] bp_exp [4];

    fpmult_round_pack_if bus ();

    fpmult_round_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic drive(input logic sgn, input logic [8:0] e, input logic [8:0] ep,
                         input logic [23:0] m, input logic [23:0] mp,
                         input logic g, input logic r, input logic s,
                         input logic nan, input logic inf, input logic zero);
        bus.Sign = sgn;  bus.RoundE = e;  bus.RoundEP = ep;
        bus.RoundM = m;  bus.RoundMP = mp;
        bus.G = g;  bus.R = r;  bus.S = s;
        bus.SpecNaN = nan;  bus.SpecInf = inf;  bus.SpecZero = zero;
    endtask

    // Called just after a posedge with inputs driven; checks exact 2-cycle latency.
    task automatic one(input string tag, input logic [31:0] expz,
                       input logic eo, input logic eu, input logic ei);
        bus.in_valid = 1'b1;
        @(negedge clk) chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk) #1 bus.in_valid = 1'b0;
        @(negedge clk) chk({tag, " early_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " Z"}, bus.Z, expz);
        chk({tag, " ovf"}, 32'(bus.flag_ovf), 32'(eo));
        chk({tag, " unf"}, 32'(bus.flag_unf), 32'(eu));
        chk({tag, " inx"}, 32'(bus.flag_inx), 32'(ei));
        @(posedge clk) #1;
    endtask

    task automatic clear_flags(input string tag);
        bus.flags_clr = 1'b1;
        @(posedge clk) #1 bus.flags_clr = 1'b0;
        @(negedge clk) chk(tag, {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'd0);
        @(posedge clk) #1;
    endtask

    initial begin
        bp_exp[0] = 32'h32000001;
        bp_exp[1] = 32'h32800002;
        bp_exp[2] = 32'h33000003;
        bp_exp[3] = 32'h33800004;

        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.out_ready = 1'b1;  bus.flags_clr = 1'b0;
        drive(0, 9'd0, 9'd0, 24'd0, 24'd0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst Z", bus.Z, 32'd0);
        chk("rst flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk) #1;

        // rounding
        drive(0, 9'd127, 9'd128, 24'h400000, 24'h400001, 1, 0, 0, 0, 0, 0);
        one("tie_even", 32'h3FC00000, 0, 0, 1);
        clear_flags("clr1");
        drive(0, 9'd127, 9'd128, 24'h400000, 24'h400001, 1, 0, 1, 0, 0, 0);
        one("round_up", 32'h3FC00001, 0, 0, 1);
        clear_flags("clr2");
        drive(0, 9'd127, 9'd128, 24'h400000, 24'h400001, 0, 1, 0, 0, 0, 0);
        one("round_dn", 32'h3FC00000, 0, 0, 1);
        drive(0, 9'd127, 9'd128, 24'h7FFFFF, 24'h800000, 1, 0, 1, 0, 0, 0);
        one("carry", 32'h40000000, 0, 0, 1);
        clear_flags("clr3");

        // exponent range edges, exact results
        drive(0, 9'd254, 9'd255, 24'h123456, 24'h123457, 0, 0, 0, 0, 0, 0);
        one("e254", 32'h7F123456, 0, 0, 0);
        drive(0, 9'd1, 9'd2, 24'h000000, 24'h000001, 0, 0, 0, 0, 0, 0);
        one("e1", 32'h00800000, 0, 0, 0);
        drive(0, 9'd254, 9'd255, 24'h7FFFFF, 24'h800000, 1, 0, 1, 0, 0, 0);
        one("ovf", 32'h7F800000, 1, 0, 1);
        clear_flags("clr4");
        drive(1, 9'h1F0, 9'h1F1, 24'h000010, 24'h000011, 0, 0, 0, 0, 0, 0);
        one("unf", 32'h80000000, 0, 1, 1);
        drive(0, 9'd0, 9'd1, 24'h200000, 24'h200001, 0, 0, 0, 0, 0, 0);
        one("e0", 32'h00000000, 0, 1, 1);
        clear_flags("clr5");

        // specials raise nothing
        drive(0, 9'd127, 9'd128, 24'h400000, 24'h400001, 1, 1, 0, 1, 0, 0);
        one("nan", 32'h7FC00000, 0, 0, 0);
        drive(1, 9'd127, 9'd128, 24'h400000, 24'h400001, 1, 0, 0, 0, 1, 0);
        one("inf", 32'hFF800000, 0, 0, 0);
        drive(1, 9'd127, 9'd128, 24'h400000, 24'h400001, 0, 0, 0, 0, 0, 1);
        one("zero", 32'h80000000, 0, 0, 0);

        // clear coinciding with the set: result flags are lost
        drive(0, 9'd254, 9'd255, 24'h7FFFFF, 24'h800000, 1, 0, 1, 0, 0, 0);
        bus.in_valid = 1'b1;
        @(posedge clk) #1 bus.in_valid = 1'b0;
        bus.flags_clr = 1'b1;
        @(posedge clk) #1 bus.flags_clr = 1'b0;
        @(negedge clk);
        chk("clr_vs_set valid", 32'(bus.out_valid), 32'd1);
        chk("clr_vs_set Z", bus.Z, 32'h7F800000);
        chk("clr_vs_set flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'd0);
        @(posedge clk) #1;

        // flags set once per result, even while stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk) #1 bus.in_valid = 1'b0;
        @(posedge clk) #1;
        @(negedge clk) chk("stall ovf set", 32'(bus.flag_ovf), 32'd1);
        @(posedge clk) #1 bus.flags_clr = 1'b1;
        @(posedge clk) #1 bus.flags_clr = 1'b0;
        @(negedge clk) chk("stall ovf clr", 32'(bus.flag_ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("stall no reset", 32'(bus.flag_ovf), 32'd0);
        chk("stall held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        @(negedge clk) chk("stall drained", 32'(bus.out_valid), 32'd0);
        @(posedge clk) #1;

        // backpressure: 5 stalled cycles with inputs offered continuously
        k_in = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(0, 9'(100 + k_in), 9'(101 + k_in), 24'(k_in + 1), 24'(k_in + 2), 0, 0, 0, 0, 0, 0);
            bus.in_valid = 1'b1;
            @(negedge clk);
            rdy = bus.in_ready;
            if (c >= 2) begin
                chk("bp in_ready low", 32'(rdy), 32'd0);
                chk("bp Z stable", bus.Z, bp_exp[0]);
            end
            @(posedge clk);
            if (rdy) k_in++;
            #1;
        end
        chk("bp accepts", 32'(k_in), 32'd2);
        bus.out_ready = 1'b1;
        k_out = 0;
        cyc   = 0;
        while ((k_out < 4 || k_in < 4) && cyc < 40) begin
            if (k_in < 4) begin
                drive(0, 9'(100 + k_in), 9'(101 + k_in), 24'(k_in + 1), 24'(k_in + 2), 0, 0, 0, 0, 0, 0);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            rdy = bus.in_ready;
            if (bus.out_valid) begin
                if (k_out < 4) chk("bp order", bus.Z, bp_exp[k_out]);
                else           chk("bp extra output", 32'(bus.out_valid), 32'd0);
                k_out++;
            end
            @(posedge clk);
            if (rdy && bus.in_valid) k_in++;
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("bp drained count", 32'(k_out), 32'd4);
        repeat (2) begin
            @(negedge clk) chk("bp no dup", 32'(bus.out_valid), 32'd0);
            @(posedge clk) #1;
        end

        // reset while full discards everything, including flags
        bus.out_ready = 1'b0;
        drive(0, 9'd254, 9'd255, 24'h7FFFFF, 24'h800000, 1, 0, 1, 0, 0, 0);
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full ovf", 32'(bus.flag_ovf), 32'd1);
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_full out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_full flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 32'd0);
        chk("rst_full Z", bus.Z, 32'd0);
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("rst_full no pulse", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
